// File: rtl/control_unit_pipe.sv
// control_unit_pipe: RV32I control decoder registered into the ID/EX boundary.
// Decodes the ID-stage instruction into a control bundle, handles stall/flush
// bubbles, flags illegal encodings and, when ENABLE_M=1, sequences multi-cycle
// mul/div ops by holding the pipeline for MUL_CYCLES/DIV_CYCLES cycles.
//
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_opcode, i_funct3, i_funct7     instruction fields from ID
//   i_valid, i_stall, i_flush        ID valid, hazard hold, branch/jump flush
//   o_valid .. o_imm_src             registered control bundle
//   o_illegal, o_md_op, o_md_div     registered encoding flags
//   o_md_busy, o_md_done             M sequencer status
//   o_stall_req                      upstream hold request (== o_md_busy)
module control_unit_pipe #(
  parameter bit          ENABLE_M   = 1'b1,
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  input  logic       i_valid,
  input  logic       i_stall,
  input  logic       i_flush,
  output logic       o_valid,
  output logic [1:0] o_result_src,
  output logic       o_mem_write,
  output logic       o_reg_write,
  output logic       o_jmp,
  output logic       o_branch,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_alu_src_opa,
  output logic       o_alu_src_opb,
  output logic [2:0] o_imm_src,
  output logic       o_illegal,
  output logic       o_md_op,
  output logic       o_md_div,
  output logic       o_md_busy,
  output logic       o_md_done,
  output logic       o_stall_req
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_M    = 7'b0000001;

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  typedef struct packed {
    logic       valid;
    logic [1:0] result_src;
    logic       mem_write;
    logic       reg_write;
    logic       jmp;
    logic       branch;
    logic [1:0] alu_op;
    logic [1:0] alu_src_opa;
    logic       alu_src_opb;
    logic [2:0] imm_src;
    logic       illegal;
    logic       md_op;
    logic       md_div;
  } bundle_t;

  typedef enum logic {IDLE, MD_RUN} state_e;

  bundle_t          dec;
  bundle_t          bundle_d, bundle_q;
  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             done_d, done_q;
  logic             is_m;

  // Low funct3 bits only matter to the ALU decoder downstream.
  logic unused_funct3;
  assign unused_funct3 = ^i_funct3[1:0];

  assign is_m = ENABLE_M && (i_funct7 == F7_M);

  // Instruction decode; illegal encodings keep only valid+illegal set.
  always_comb begin
    dec = '0;
    if (i_valid) begin
      dec.valid = 1'b1;
      case (i_opcode)
        OP_R: begin
          if (i_funct7 == F7_BASE || i_funct7 == F7_ALT || is_m) begin
            dec.reg_write = 1'b1;
            dec.alu_op    = 2'b10;
            dec.md_op     = is_m;
            dec.md_div    = is_m & i_funct3[2];
          end else begin
            dec.illegal = 1'b1;
          end
        end
        OP_LW: begin
          dec.result_src  = 2'b01;
          dec.reg_write   = 1'b1;
          dec.alu_src_opb = 1'b1;
        end
        OP_ADDI: begin
          dec.reg_write   = 1'b1;
          dec.alu_src_opb = 1'b1;
        end
        OP_JALR: begin
          dec.result_src  = 2'b10;
          dec.reg_write   = 1'b1;
          dec.jmp         = 1'b1;
          dec.alu_src_opb = 1'b1;
        end
        OP_SW: begin
          dec.result_src  = 2'b11;
          dec.mem_write   = 1'b1;
          dec.alu_src_opb = 1'b1;
          dec.imm_src     = 3'b001;
        end
        OP_JAL: begin
          dec.result_src = 2'b10;
          dec.reg_write  = 1'b1;
          dec.jmp        = 1'b1;
          dec.imm_src    = 3'b011;
        end
        OP_BEQ: begin
          dec.result_src = 2'b11;
          dec.branch     = 1'b1;
          dec.alu_op     = 2'b11;
          dec.imm_src    = 3'b010;
        end
        OP_LUI: begin
          dec.reg_write   = 1'b1;
          dec.alu_src_opb = 1'b1;
          dec.alu_src_opa = 2'b10;
          dec.imm_src     = 3'b100;
        end
        OP_AUIPC: begin
          dec.reg_write   = 1'b1;
          dec.alu_src_opb = 1'b1;
          dec.alu_src_opa = 2'b01;
          dec.imm_src     = 3'b100;
        end
        default: dec.illegal = 1'b1;
      endcase
    end
  end

  // Next state: flush > MD_RUN hold > stall hold > load.
  always_comb begin
    bundle_d = bundle_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    if (i_flush) begin
      bundle_d = '0;
      state_d  = IDLE;
      cnt_d    = '0;
    end else if (state_q == MD_RUN && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      // Idle, or the last MD_RUN cycle: a new M op may start with no gap.
      state_d = IDLE;
      cnt_d   = '0;
      if (!i_stall) begin
        bundle_d = dec;
        if (dec.md_op) begin
          state_d = MD_RUN;
          cnt_d   = dec.md_div ? DIV_LAST : MUL_LAST;
        end
      end
    end
    // Done is registered: it marks the MD_RUN cycle whose counter is zero.
    done_d = (state_d == MD_RUN) && (cnt_d == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bundle_q <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      bundle_q <= bundle_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign o_valid       = bundle_q.valid;
  assign o_result_src  = bundle_q.result_src;
  assign o_mem_write   = bundle_q.mem_write;
  assign o_reg_write   = bundle_q.reg_write;
  assign o_jmp         = bundle_q.jmp;
  assign o_branch      = bundle_q.branch;
  assign o_alu_op      = bundle_q.alu_op;
  assign o_alu_src_opa = bundle_q.alu_src_opa;
  assign o_alu_src_opb = bundle_q.alu_src_opb;
  assign o_imm_src     = bundle_q.imm_src;
  assign o_illegal     = bundle_q.illegal;
  assign o_md_op       = bundle_q.md_op;
  assign o_md_div      = bundle_q.md_div;
  assign o_md_busy     = (state_q == MD_RUN);
  assign o_md_done     = done_q;
  assign o_stall_req   = (state_q == MD_RUN);

endmodule
